gray_conv_arbiter: RTL and testbench



---
 rtl/gray_conv_arbiter.sv | 131 +++++++++++++
 tb/tb_gray_conv_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Shared binary<->Gray conversion engine with a round-robin front end.
// B2G completes in one cycle; G2B resolves one prefix-XOR bit per cycle, MSB first.
module gray_conv_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_mode
);
    localparam int unsigned KW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StB2g, StG2b, StDone} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   op_q, op_d;
    logic [W-1:0]   res_q, res_d;
    logic           mode_q, mode_d;
    logic [KW-1:0]  k_q, k_d;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic [W-1:0]   sel_data;

    // NREQ is a power of two, so the IDW-bit add wraps the search naturally.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            idx = ptr_q + IDW'(o);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_data = req_data[W*i +: W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        res_d     = res_q;
        mode_d    = mode_q;
        k_d       = k_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    op_d   = sel_data;
                    id_d   = win;
                    mode_d = req_mode[win];
                    ptr_d  = win + IDW'(1);
                    if (req_mode[win]) begin
                        res_d   = {sel_data[W-1], res_q[W-2:0]};
                        k_d     = KW'(W - 2);
                        state_d = StG2b;
                    end else begin
                        state_d = StB2g;
                    end
                end
            end
            StB2g: begin
                res_d   = op_q ^ (op_q >> 1);
                state_d = StDone;
            end
            StG2b: begin
                res_d[k_q] = res_q[k_q + KW'(1)] ^ op_q[k_q];
                k_d        = k_q - KW'(1);
                if (k_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_data  = res_q;
    assign out_id    = id_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench: expectations are queued at accept and popped by a negedge monitor.
module tb_gray_conv_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_mode;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              out_mode;

    gray_conv_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic           m;
    } exp_t;

    exp_t            sbq[$];
    exp_t            e;
    logic [W-1:0]    exp_by_req [NREQ];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              xfers = 0;
    int              mptr = 0;
    int              acc_cyc = 0;
    int              lat = 0;
    int              win;
    bit              busy = 0;
    bit              was_busy;
    bit              vprev = 0;
    logic [NREQ-1:0] granted = '0;
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0]    last_out;

    function automatic logic [W-1:0] b2g_m(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [W-1:0] g2b_m(input logic [W-1:0] g);
        logic [W-1:0] b = g;
        for (int s = 1; s < int'(W); s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        granted = '0;
        if (rst) begin
            busy  = 0;
            mptr  = 0;
            vprev = 0;
            sbq.delete();
        end else begin
            was_busy = busy;
            if (!was_busy) chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
            win = -1;
            if (!was_busy) begin
                for (int o = 0; o < int'(NREQ); o++) begin
                    if (win < 0 && req_valid[(mptr + o) % NREQ]) win = (mptr + o) % NREQ;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
            if (win >= 0) begin
                e.d  = exp_by_req[win];
                e.id = IDW'(win);
                e.m  = req_mode[win];
                sbq.push_back(e);
                busy       = 1;
                mptr       = (win + 1) % NREQ;
                acc_cyc    = cyc;
                lat        = req_mode[win] ? int'(W) : 2;
                granted[win] = 1'b1;
            end
            if (was_busy) begin
                if (cyc == acc_cyc + lat) chk("latency_valid", {31'd0, out_valid}, 32'd1);
                if (out_valid && !vprev) chk("first_valid_cycle", cyc - acc_cyc, lat);
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        chk("scoreboard_nonempty", 32'd0, 32'd1);
                    end else begin
                        chk("out_data", {24'd0, out_data}, {24'd0, sbq[0].d});
                        chk("out_id", {30'd0, out_id}, {30'd0, sbq[0].id});
                        chk("out_mode", {31'd0, out_mode}, {31'd0, sbq[0].m});
                        if (out_ready) begin
                            void'(sbq.pop_front());
                            last_out = out_data;
                            busy     = 0;
                            xfers++;
                        end
                    end
                end
            end
            vprev = out_valid && !out_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~granted;
    endtask

    task automatic issue(input int i, input logic m, input logic [W-1:0] d,
                         input logic [W-1:0] expv);
        req_valid[i]      = 1'b1;
        req_mode[i]       = m;
        req_data[W*i +: W] = d;
        exp_by_req[i]     = expv;
    endtask

    task automatic wait_xfer(input int target, input string what);
        int t = 0;
        while (xfers < target && t < 300) begin
            step();
            t++;
        end
        checks++;
        if (xfers < target) begin
            errors++;
            $display("FAIL %s timeout got %0d transfers expected %0d", what, xfers, target);
        end
    endtask

    initial begin
        int n0;
        int t;
        logic [W-1:0] gv;
        logic         m;
        logic [W-1:0] d;

        rst = 1'b1; req_valid = '0; req_mode = '0; req_data = '0; out_ready = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) exp_by_req[i] = '0;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_id", {30'd0, out_id}, 32'd0);
        chk("rst_out_mode", {31'd0, out_mode}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        issue(0, 1'b0, 8'h5C, 8'h72); n0 = xfers; wait_xfer(n0 + 1, "b2g_5c");
        issue(0, 1'b0, 8'h00, 8'h00); n0 = xfers; wait_xfer(n0 + 1, "b2g_00");
        issue(2, 1'b1, 8'h72, 8'h5C); n0 = xfers; wait_xfer(n0 + 1, "g2b_72");
        issue(2, 1'b1, 8'h80, 8'hFF); n0 = xfers; wait_xfer(n0 + 1, "g2b_80");

        // Round-robin from a freshly reset pointer.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) issue(i, 1'b0, 8'hFF, 8'h80);
        n0 = xfers; wait_xfer(n0 + 4, "rr_four");
        issue(0, 1'b0, 8'hFF, 8'h80); n0 = xfers; wait_xfer(n0 + 1, "rr_wrap0");
        issue(1, 1'b0, 8'h11, b2g_m(8'h11)); n0 = xfers; wait_xfer(n0 + 1, "rr_ptr2");
        issue(1, 1'b0, 8'h22, b2g_m(8'h22)); n0 = xfers; wait_xfer(n0 + 1, "rr_only1");

        // Backpressure with a competing requester pending.
        out_ready = 1'b0;
        issue(3, 1'b0, 8'h01, 8'h01);
        t = 0;
        while (!out_valid && t < 50) begin step(); t++; end
        chk("bp_valid_rises", {31'd0, out_valid}, 32'd1);
        issue(1, 1'b0, 8'h33, b2g_m(8'h33));
        for (int i = 0; i < 5; i++) step();
        n0 = xfers;
        out_ready = 1'b1;
        step();
        chk("bp_single_xfer", xfers - n0, 32'd1);
        wait_xfer(n0 + 2, "bp_req1");

        // Reset three cycles into a G2B operation.
        issue(2, 1'b1, 8'hA5, g2b_m(8'hA5));
        t = 0;
        while (req_valid[2] && t < 20) begin step(); t++; end
        step(); step();
        rst = 1'b1; req_valid = '0;
        step();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        rst = 1'b0;
        n0 = xfers;
        for (int i = 0; i < 12; i++) step();
        chk("midrst_no_output", xfers - n0, 32'd0);
        issue(0, 1'b0, 8'h5C, 8'h72); wait_xfer(n0 + 1, "midrst_follow");

        for (int v = 0; v < 256; v++) begin
            issue(1, 1'b0, W'(v), b2g_m(W'(v)));
            n0 = xfers; wait_xfer(n0 + 1, "rt_b2g");
            gv = last_out;
            issue(2, 1'b1, gv, W'(v));
            wait_xfer(n0 + 2, "rt_g2b");
        end

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    m = 1'($urandom_range(0, 1));
                    d = W'($urandom);
                    issue(i, m, d, m ? g2b_m(d) : b2g_m(d));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        t = 0;
        while ((req_valid != '0 || busy) && t < 400) begin step(); t++; end
        chk("drain_idle", {31'd0, busy}, 32'd0);
        chk("drain_sbq_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
